pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the SiMPLE cores: holds the fetch PC, advances it sequentially under a valid/ready handshake with the fetch stage, and applies prioritised redirects from branch/jump resolution, trap entry and `mret`. It also keeps the saved exception PC, detects misaligned redirect targets, and parks in a fault state until the CSR unit takes the trap. It sits between the execute/CSR logic and instruction fetch, and replaces the fixed 32-bit PC register.

---
 rtl/pc_pkg.sv | 18 +
 rtl/pc_sequencer_if.sv | 35 +++
 rtl/pc_next_sel.sv | 73 +++++++
 rtl/pc_sequencer.sv | 98 +++++++++
 tb/tb_pc_sequencer.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared types for the SiMPLE program-counter sequencer and its next-PC selector.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FAULT
  } seq_state_e;

  typedef enum logic [2:0] {
    SEQ,
    HOLD,
    REDIRECT,
    TRAP,
    MRET
  } next_sel_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus between the PC sequencer and its execute/CSR/fetch neighbours.
// The master modport is the sequencer side and the slave modport is the environment side.
interface pc_sequencer_if #(
  parameter int XLEN = 64
);

  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic            fetch_ready;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] redirect_src_pc;
  logic            trap_valid;
  logic [XLEN-1:0] trap_vector;
  logic [XLEN-1:0] trap_epc;
  logic            mret_valid;
  logic [XLEN-1:0] epc;
  logic            misaligned_valid;
  logic [XLEN-1:0] misaligned_addr;
  logic [XLEN-1:0] misaligned_epc;

  modport master (
    output pc, pc_valid, epc, misaligned_valid, misaligned_addr, misaligned_epc,
    input  fetch_ready, stall, redirect_valid, redirect_target, redirect_src_pc,
           trap_valid, trap_vector, trap_epc, mret_valid
  );

  modport slave (
    input  pc, pc_valid, epc, misaligned_valid, misaligned_addr, misaligned_epc,
    output fetch_ready, stall, redirect_valid, redirect_target, redirect_src_pc,
           trap_valid, trap_vector, trap_epc, mret_valid
  );

endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection for the PC sequencer.
// Produces the prioritised source, the misaligned-redirect decision and the next PC value.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int INSTR_BYTES = 4,
  parameter int ALIGN_BITS  = 2
) (
  input  seq_state_e      state,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] epc,
  input  logic            fetch_ready,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            mret_valid,
  output next_sel_e       sel,
  output logic            misaligned,
  output logic [XLEN-1:0] next_pc
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN - ALIGN_BITS){1'b1}}, {ALIGN_BITS{1'b0}}};
  localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);

  logic target_misaligned;

  assign target_misaligned = (redirect_target[ALIGN_BITS-1:0] != '0);

  // Flush events win over the handshake; a misaligned redirect holds the PC and raises the fault.
  always_comb begin
    sel        = HOLD;
    misaligned = 1'b0;
    case (state)
      RUN: begin
        if (trap_valid) begin
          sel = TRAP;
        end else if (mret_valid) begin
          sel = MRET;
        end else if (redirect_valid) begin
          if (target_misaligned) begin
            misaligned = 1'b1;
          end else begin
            sel = REDIRECT;
          end
        end else if (fetch_ready && !stall) begin
          sel = SEQ;
        end
      end
      FAULT: begin
        if (trap_valid) begin
          sel = TRAP;
        end
      end
      default: begin
        sel = HOLD;
      end
    endcase
  end

  always_comb begin
    case (sel)
      SEQ:      next_pc = pc + STEP;
      REDIRECT: next_pc = redirect_target;
      TRAP:     next_pc = trap_vector & ALIGN_MASK;
      MRET:     next_pc = epc;
      default:  next_pc = pc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-PC sequencer: holds pc/epc and the misaligned-fault record, stepping BOOT -> RUN,
// and parking in FAULT after a misaligned redirect until the CSR unit takes the trap.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INSTR_BYTES  = 4,
  parameter int              ALIGN_BITS   = 2
) (
  input logic          clk,
  input logic          rst,
  pc_sequencer_if.master bus
);

  seq_state_e      state;
  next_sel_e       sel;
  logic            misaligned;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] mis_addr_q;
  logic [XLEN-1:0] mis_epc_q;
  logic            pc_valid_q;
  logic            mis_valid_q;

  pc_next_sel #(
    .XLEN        (XLEN),
    .INSTR_BYTES (INSTR_BYTES),
    .ALIGN_BITS  (ALIGN_BITS)
  ) u_next_sel (
    .state           (state),
    .pc              (pc_q),
    .epc             (epc_q),
    .fetch_ready     (bus.fetch_ready),
    .stall           (bus.stall),
    .redirect_valid  (bus.redirect_valid),
    .redirect_target (bus.redirect_target),
    .trap_valid      (bus.trap_valid),
    .trap_vector     (bus.trap_vector),
    .mret_valid      (bus.mret_valid),
    .sel             (sel),
    .misaligned      (misaligned),
    .next_pc         (next_pc)
  );

  // pc_valid is registered alongside the state so it reads 1 exactly while in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc_q        <= RESET_VECTOR;
      epc_q       <= '0;
      pc_valid_q  <= 1'b0;
      mis_valid_q <= 1'b0;
      mis_addr_q  <= '0;
      mis_epc_q   <= '0;
    end else begin
      mis_valid_q <= 1'b0;
      pc_q        <= next_pc;
      if (sel == TRAP) begin
        epc_q <= bus.trap_epc;
      end
      case (state)
        BOOT: begin
          state      <= RUN;
          pc_valid_q <= 1'b1;
        end
        RUN: begin
          if (misaligned) begin
            state       <= FAULT;
            pc_valid_q  <= 1'b0;
            mis_valid_q <= 1'b1;
            mis_addr_q  <= bus.redirect_target;
            mis_epc_q   <= bus.redirect_src_pc;
          end
        end
        FAULT: begin
          if (sel == TRAP) begin
            state      <= RUN;
            pc_valid_q <= 1'b1;
          end
        end
        default: begin
          state      <= BOOT;
          pc_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc               = pc_q;
  assign bus.pc_valid         = pc_valid_q;
  assign bus.epc              = epc_q;
  assign bus.misaligned_valid = mis_valid_q;
  assign bus.misaligned_addr  = mis_addr_q;
  assign bus.misaligned_epc   = mis_epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer (XLEN=32, reset vector 0x1000): a cycle-level reference model compared
// against every output each cycle, plus literal expectations taken from the sequencer's test plan.
module tb_pc_sequencer;

  localparam int          XLEN       = 32;
  localparam logic [31:0] RV         = 32'h1000;
  localparam int          STEP_BYTES = 4;
  localparam int          ALIGN_UNIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pc_sequencer_if #(.XLEN(XLEN)) bus ();

  pc_sequencer #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RV),
    .INSTR_BYTES  (STEP_BYTES),
    .ALIGN_BITS   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc, m_epc, m_mis_addr, m_mis_epc;
  bit          m_valid, m_mis_valid, m_boot, m_fault;
  bit          m_live = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the behaviour in plain terms, updated from the inputs seen at each edge.
  always @(posedge clk) begin
    if (rst) begin
      m_live = 1'b1;
      m_boot = 1'b1;
      m_fault = 1'b0;
      m_pc = RV;
      m_epc = 32'h0;
      m_valid = 1'b0;
      m_mis_valid = 1'b0;
      m_mis_addr = 32'h0;
      m_mis_epc = 32'h0;
    end else if (m_live) begin
      m_mis_valid = 1'b0;
      if (m_boot) begin
        m_boot = 1'b0;
        m_valid = 1'b1;
      end else if (bus.trap_valid) begin
        m_pc = bus.trap_vector - (bus.trap_vector % ALIGN_UNIT);
        m_epc = bus.trap_epc;
        m_fault = 1'b0;
        m_valid = 1'b1;
      end else if (!m_fault) begin
        if (bus.mret_valid) begin
          m_pc = m_epc;
        end else if (bus.redirect_valid) begin
          if ((bus.redirect_target % ALIGN_UNIT) != 0) begin
            m_fault = 1'b1;
            m_valid = 1'b0;
            m_mis_valid = 1'b1;
            m_mis_addr = bus.redirect_target;
            m_mis_epc = bus.redirect_src_pc;
          end else begin
            m_pc = bus.redirect_target;
          end
        end else if (bus.fetch_ready && !bus.stall) begin
          m_pc = m_pc + STEP_BYTES;
        end
      end
    end
    #1;
    if (m_live) begin
      check_output("pc", bus.pc, m_pc);
      check_output("pc_valid", {31'b0, bus.pc_valid}, {31'b0, m_valid});
      check_output("epc", bus.epc, m_epc);
      check_output("misaligned_valid", {31'b0, bus.misaligned_valid}, {31'b0, m_mis_valid});
      check_output("misaligned_addr", bus.misaligned_addr, m_mis_addr);
      check_output("misaligned_epc", bus.misaligned_epc, m_mis_epc);
    end
  end

  task automatic apply_stimulus(input logic r, input logic rdy, input logic stl,
                                input logic rv, input logic [31:0] rt, input logic [31:0] rsrc,
                                input logic tv, input logic [31:0] tvec, input logic [31:0] tepc,
                                input logic mr);
    rst                 = r;
    bus.fetch_ready     = rdy;
    bus.stall           = stl;
    bus.redirect_valid  = rv;
    bus.redirect_target = rt;
    bus.redirect_src_pc = rsrc;
    bus.trap_valid      = tv;
    bus.trap_vector     = tvec;
    bus.trap_epc        = tepc;
    bus.mret_valid      = mr;
    @(posedge clk);
    #2;
  endtask

  initial begin
    apply_stimulus(1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);
    apply_stimulus(1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);
    check_output("reset pc", bus.pc, 32'h1000);
    check_output("reset pc_valid", {31'b0, bus.pc_valid}, 32'h0);
    check_output("reset epc", bus.epc, 32'h0);

    apply_stimulus(0, 1, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);
    check_output("boot exit pc_valid", {31'b0, bus.pc_valid}, 32'h1);
    check_output("first pc", bus.pc, 32'h1000);
    apply_stimulus(0, 1, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);
    check_output("seq pc 1", bus.pc, 32'h1004);
    apply_stimulus(0, 1, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);
    apply_stimulus(0, 1, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);
    check_output("seq pc 3", bus.pc, 32'h100C);

    apply_stimulus(0, 1, 0, 1, 32'h2000, 32'h100C, 0, 32'h0, 32'h0, 0);
    check_output("redirect pc", bus.pc, 32'h2000);
    apply_stimulus(0, 1, 1, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);
    check_output("stall hold", bus.pc, 32'h2000);
    apply_stimulus(0, 1, 1, 1, 32'h3000, 32'h2000, 0, 32'h0, 32'h0, 0);
    check_output("redirect under stall", bus.pc, 32'h3000);

    apply_stimulus(0, 1, 0, 1, 32'h4000, 32'h3000, 1, 32'h8003, 32'h2004, 1);
    check_output("trap wins pc", bus.pc, 32'h8000);
    check_output("trap epc", bus.epc, 32'h2004);
    apply_stimulus(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);
    check_output("no ready hold", bus.pc, 32'h8000);
    apply_stimulus(0, 0, 1, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 1);
    check_output("mret pc", bus.pc, 32'h2004);

    apply_stimulus(0, 1, 0, 1, 32'h3002, 32'h2010, 0, 32'h0, 32'h0, 0);
    check_output("fault pc held", bus.pc, 32'h2004);
    check_output("fault pulse", {31'b0, bus.misaligned_valid}, 32'h1);
    check_output("fault addr", bus.misaligned_addr, 32'h3002);
    check_output("fault epc", bus.misaligned_epc, 32'h2010);
    check_output("fault pc_valid", {31'b0, bus.pc_valid}, 32'h0);
    apply_stimulus(0, 1, 0, 1, 32'h4000, 32'h2014, 0, 32'h0, 32'h0, 1);
    check_output("fault ignores redirect", bus.pc, 32'h2004);
    check_output("fault pulse ends", {31'b0, bus.misaligned_valid}, 32'h0);
    check_output("fault addr holds", bus.misaligned_addr, 32'h3002);
    apply_stimulus(0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h8000, 32'h2010, 0);
    check_output("trap leaves fault pc", bus.pc, 32'h8000);
    check_output("trap leaves fault valid", {31'b0, bus.pc_valid}, 32'h1);
    apply_stimulus(0, 1, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);
    check_output("run after fault", bus.pc, 32'h8004);

    apply_stimulus(0, 1, 0, 1, 32'hFFFFFFFC, 32'h8004, 0, 32'h0, 32'h0, 0);
    apply_stimulus(0, 1, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);
    check_output("wrap pc", bus.pc, 32'h0);
    apply_stimulus(0, 1, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);
    check_output("after wrap", bus.pc, 32'h4);

    apply_stimulus(0, 1, 0, 1, 32'h5001, 32'h0004, 0, 32'h0, 32'h0, 0);
    check_output("second fault addr", bus.misaligned_addr, 32'h5001);
    apply_stimulus(1, 1, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);
    check_output("reset in fault pc", bus.pc, 32'h1000);
    check_output("reset in fault epc", bus.epc, 32'h0);
    check_output("reset in fault addr", bus.misaligned_addr, 32'h0);
    check_output("reset in fault mepc", bus.misaligned_epc, 32'h0);
    check_output("reset in fault valid", {31'b0, bus.pc_valid}, 32'h0);
    apply_stimulus(0, 1, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);
    check_output("reboot valid", {31'b0, bus.pc_valid}, 32'h1);
    apply_stimulus(0, 1, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);
    check_output("reboot seq", bus.pc, 32'h1004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
